// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants for the VGA pixel path: pattern-source encodings, colour-bar
// geometry and the sync-polarity helper used to pick idle sync levels.
// Ports: none (package).
package vga_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_GRAD  = 2'd3;

  localparam int BAR_COUNT = 8;
  localparam int BAR_IDX_W = 3;

  // Default sync polarity of the sync generator (active low).
  localparam bit SYNC_ACTIVE_LOW_DEFAULT = 1'b1;

  // Inactive sync level: an active-low sync idles high, an active-high one idles low.
  function automatic logic sync_idle(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Combinational pattern source: maps the current pixel position plus the
// frame-latched mode/level and frame counter to an RGB triple.
// Ports:
//   x, y       in   pixel column / row
//   mode       in   frame-latched pattern select
//   level      in   frame-latched user colour/level
//   frame_cnt  in   frame counter (scrolls the gradient)
//   red/green/blue out  pattern colour, not yet blank-gated
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W   = 8,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int BAR_W     = 80,
  parameter int CHK_SHIFT = 5,
  parameter int FRAME_W   = 8
) (
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] level,
  input  logic [FRAME_W-1:0] frame_cnt,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  logic [BAR_IDX_W-1:0] bar_idx;
  logic                 chk_bit;

  // Bar index is the number of bar boundaries already passed; with seven
  // boundaries it naturally tops out at 7 for anything right of the last one.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < BAR_COUNT; i++) begin
      if (32'(x) >= 32'(i * BAR_W)) begin
        bar_idx = bar_idx + BAR_IDX_W'(1);
      end
    end
  end

  assign chk_bit = x[CHK_SHIFT] ^ y[CHK_SHIFT];

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    case (mode)
      MODE_SOLID: begin
        red   = level;
        green = level;
        blue  = level;
      end
      MODE_BARS: begin
        // white, yellow, cyan, green, magenta, red, blue, black
        red   = {COLOR_W{~bar_idx[1]}};
        green = {COLOR_W{~bar_idx[2]}};
        blue  = {COLOR_W{~bar_idx[0]}};
      end
      MODE_CHECK: begin
        if (chk_bit) begin
          red   = level;
          green = level;
          blue  = level;
        end
      end
      MODE_GRAD: begin
        red   = COLOR_W'(x) + COLOR_W'(frame_cnt);
        green = COLOR_W'(y);
        blue  = level;
      end
      default: begin
        red   = '0;
        green = '0;
        blue  = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_pixel_stage.sv
// vga_pixel_stage
// Pixel output stage: frame-edge detector, per-frame latches for mode/level,
// frame counter, and a fixed two-stage pipeline that keeps RGB, blanking and
// syncs aligned on their way to the DAC/connector.
// Ports:
//   vga_clock, rst            pixel clock, async active-high reset
//   x, y, video_on            pixel position and active-area flag
//   hsync_in, vsync_in        syncs from the generator
//   mode, sw                  requested pattern and colour/level (latched per frame)
//   red, green, blue          pixel colour, zero while blanked
//   hsync_out, vsync_out      syncs delayed two cycles
//   blank_n                   video_on delayed two cycles
//   sync_n                    tied high (no sync-on-green)
//   frame_cnt                 frames since reset, wrapping
module vga_pixel_stage
  import vga_pkg::*;
#(
  parameter int COLOR_W         = 8,
  parameter int X_W             = 10,
  parameter int Y_W             = 10,
  parameter int BAR_W           = 80,
  parameter int CHK_SHIFT       = 5,
  parameter int FRAME_W         = 8,
  parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEFAULT
) (
  input  logic               vga_clock,
  input  logic               rst,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] sw,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_n,
  output logic               sync_n,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic SYNC_IDLE = sync_idle(SYNC_ACTIVE_LOW);

  logic [1:0]         mode_q;
  logic [COLOR_W-1:0] sw_q;
  logic               vsync_q;
  logic               armed;
  logic               frame_edge;

  logic [COLOR_W-1:0] pat_red, pat_green, pat_blue;

  logic [COLOR_W-1:0] s1_red, s1_green, s1_blue;
  logic               s1_video, s1_hsync, s1_vsync;

  // armed stays low for the first cycle after reset so that a vsync already
  // active at release (vsync_q still holding the idle level) is not taken as an edge.
  assign frame_edge = armed && (vsync_q != vsync_in) && (vsync_in != SYNC_IDLE);

  always_ff @(posedge vga_clock or posedge rst) begin
    if (rst) begin
      vsync_q   <= SYNC_IDLE;
      armed     <= 1'b0;
      mode_q    <= MODE_SOLID;
      sw_q      <= '0;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync_in;
      armed   <= 1'b1;
      if (frame_edge) begin
        mode_q    <= mode;
        sw_q      <= sw;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  vga_pattern_gen #(
    .COLOR_W  (COLOR_W),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .BAR_W    (BAR_W),
    .CHK_SHIFT(CHK_SHIFT),
    .FRAME_W  (FRAME_W)
  ) u_pattern (
    .x        (x),
    .y        (y),
    .mode     (mode_q),
    .level    (sw_q),
    .frame_cnt(frame_cnt),
    .red      (pat_red),
    .green    (pat_green),
    .blue     (pat_blue)
  );

  always_ff @(posedge vga_clock or posedge rst) begin
    if (rst) begin
      s1_red    <= '0;
      s1_green  <= '0;
      s1_blue   <= '0;
      s1_video  <= 1'b0;
      s1_hsync  <= SYNC_IDLE;
      s1_vsync  <= SYNC_IDLE;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      blank_n   <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      s1_red    <= pat_red;
      s1_green  <= pat_green;
      s1_blue   <= pat_blue;
      s1_video  <= video_on;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      red       <= s1_video ? s1_red   : '0;
      green     <= s1_video ? s1_green : '0;
      blue      <= s1_video ? s1_blue  : '0;
      blank_n   <= s1_video;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

  assign sync_n = 1'b1;

endmodule

// File: doc/vga_pixel_stage.md
# vga_pixel_stage

Parametrised pixel output stage for the VGA path, driven by the sync generator's `x`/`y`/`video_on`/`hsync`/`vsync`. It replaces the single switch-driven grey buffer with four frame-latched pixel sources: solid colour, colour bars, checkerboard, and a scrolling gradient. It has a fixed two-cycle pipeline. Sync and blanking outputs are delayed to stay aligned with RGB and go straight to the DAC/connector pins.

## Interface
Parameters:
- `COLOR_W`, 8, bits per colour channel
- `X_W`, 10, width of `x`
- `Y_W`, 10, width of `y`
- `BAR_W`, 80, pixel width of one colour bar (8 bars)
- `CHK_SHIFT`, 5, checker square size is 2^CHK_SHIFT pixels
- `FRAME_W`, 8, frame counter width
- `SYNC_ACTIVE_LOW`, 1, polarity of `vsync_in`, used for frame-edge detection

Ports (reset rst, asynchronous, active-high; clock vga_clock):
- `vga_clock`  in  1  pixel clock
- `rst`  in  1  async active-high reset
- `x`  in  X_W  current column
- `y`  in  Y_W  current row
- `video_on`  in  1  active-area flag
- `hsync_in`  in  1  horizontal sync from generator
- `vsync_in`  in  1  vertical sync from generator
- `mode`  in  2  requested pattern source
- `sw`  in  COLOR_W  user colour/level
- `red`  out  COLOR_W  red channel
- `green`  out  COLOR_W  green channel
- `blue`  out  COLOR_W  blue channel
- `hsync_out`  out  1  hsync delayed 2 cycles
- `vsync_out`  out  1  vsync delayed 2 cycles
- `blank_n`  out  1  `video_on` delayed 2 cycles
- `sync_n`  out  1  constant 1 (no sync-on-green)
- `frame_cnt`  out  FRAME_W  frames since reset

## Operation
**Frame edge**
- Definition: the cycle where `vsync_in` transitions to its active level, i.e. falling when `SYNC_ACTIVE_LOW`=1. Detected against a registered copy of `vsync_in`.
- On a frame edge:
  - `mode_q <= mode`
  - `sw_q <= sw`
  - `frame_cnt <= frame_cnt+1`, wrapping modulo 2^FRAME_W.
- `mode` and `sw` changes mid-frame have no visible effect until the next frame edge.

**Modes** (all arithmetic truncating, unsigned):
- `MODE_SOLID` (0): R=G=B=`sw_q`.
- `MODE_BARS` (1):
  - Bar index `idx` = count of i in 1..7 with x ≥ i·BAR_W, saturating at 7.
  - R = all-ones if `~idx[1]`, G = all-ones if `~idx[2]`, B = all-ones if `~idx[0]`, otherwise 0.
  - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
- `MODE_CHECK` (2): if `x[CHK_SHIFT]^y[CHK_SHIFT]`, R=G=B=`sw_q`; else 0.
- `MODE_GRAD` (3): R=(x+frame_cnt) mod 2^COLOR_W; G=y mod 2^COLOR_W; B=`sw_q`.

**Pipeline**
- Stage 1 registers the pattern RGB, `video_on`, `hsync_in` and `vsync_in`.
- Stage 2 registers the final RGB, gated to 0 when the stage-1 `video_on` is low, plus the syncs and `blank_n`.
- Output RGB is therefore 0 whenever `blank_n`=0.

**Reset** (async):
- red/green/blue=0, blank_n=0, frame_cnt=0.
- hsync_out, vsync_out, and the registered previous-vsync copy take the inactive level (1 if SYNC_ACTIVE_LOW else 0).
- mode_q=MODE_SOLID, sw_q=0, all pipeline stages cleared.
- Reset asserted mid-frame clears immediately. After release, the first frame edge is the next active-going vsync transition. A vsync_in already active at release does not count as an edge.

## Timing
- Latency: exactly 2 vga_clock cycles from `x`/`y`/`video_on`/`hsync_in`/`vsync_in` to the corresponding `red`/`green`/`blue`/`blank_n`/`hsync_out`/`vsync_out`. All outputs share this latency.
- Frame edge at input cycle N:
  - `mode_q`, `sw_q` and `frame_cnt` update at the end of cycle N.
  - Pixels sampled at cycle N+1 onward use the new values, and appear at output N+3.
  - `frame_cnt` output changes 1 cycle after the edge; it is not pipeline-delayed.
- Frame edge coinciding with a `mode` change: the value present at the edge cycle is captured.
- No handshake: one pixel per cycle, continuous.

## Structure
- Shared package `vga_pkg`:
  - Mode localparams MODE_SOLID/BARS/CHECK/GRAD as 2-bit constants.
  - Bar count (8).
  - Sync-polarity helper constant.
- One sub-module: `vga_pattern_gen`, combinational x/y/mode_q/sw_q/frame_cnt → RGB. The top holds the frame-edge detector, latches, counter and the 2-stage pipeline.

## Test plan
- **Reset:** assert rst mid-frame → same cycle RGB=0, blank_n=0, frame_cnt=0, syncs inactive. Release; mode 0, sw=8'hA5; one vsync edge → active pixels output 8'hA5 on all channels, exactly 2 cycles after input.
- **Deferred mode change:** mode 0→1 mid-frame → output stays solid until the next vsync edge, then bars. At the edge cycle itself the new mode is captured.
- **Bars boundaries:** x=0 → FF/FF/FF; x=79 → FF/FF/FF; x=80 → FF/FF/00; x=559 → 00/00/FF; x=560 → 00/00/00; x=639 → 00/00/00.
- **Blanking and alignment:** video_on low with mode 1 → RGB=0 and blank_n=0. hsync_out/vsync_out equal the inputs delayed exactly 2 cycles over a full line.
- **Checkerboard:** mode 2, sw=8'h3C, CHK_SHIFT=5 → (x=0,y=0)=0; (32,0)=3C; (32,32)=0.
- **Counter wrap:** run 256 vsync edges → frame_cnt goes 255→0. Mode 3 at x=10 after 250 frames → R=(10+250) mod 256=4.
